regfile_arbiter: RTL and testbench
==================================

# regfile_arbiter

- Sequences and shares the single register-file access port between two requesters: master (port M, initialisation traffic) and slave (port S, multiplier results).
- Replaces ad-hoc combinational muxing of exec/write/address/data with a registered one-transaction-at-a-time FSM.
- Provides grant, completion and read-data return per requester, plus address range checking.

## Interface

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- RF_DEPTH, 32, number of valid register-file entries; addresses >= RF_DEPTH are errors
- RF_LAT, 1, register-file read latency in cycles after the exec cycle (>= 1)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- m_req, s_req  in  1  request; hold high with stable fields until done
- m_write, s_write  in  1  1 = write, 0 = read
- m_addr, s_addr  in  ADDR_W  register address
- m_wdata, s_wdata  in  DATA_W  write data
- m_gnt, s_gnt  out  1  high while that port owns the register file
- m_done, s_done  out  1  one-cycle completion pulse
- m_err, s_err  out  1  valid with done; out-of-range address
- m_rdata, s_rdata  out  DATA_W  last read result for that port; held until that port's next successful read
- rf_exec  out  1  register-file access strobe, one cycle per transaction
- rf_write  out  1  write enable, qualified by rf_exec
- rf_addr  out  ADDR_W  register-file address
- rf_wdata  out  DATA_W  register-file write data
- rf_rdata  in  DATA_W  register-file read data
- busy  out  1  FSM not in IDLE

## Operation

FSM states: IDLE, ISSUE, WAIT, DONE.

- **IDLE:** if any req is high, arbitrate, latch the winner's write/addr/wdata into internal registers, record the owner, and go to ISSUE. Otherwise stay in IDLE.
- **ISSUE:** the owner's gnt is high.
  - In range: rf_exec=1 with latched fields.
  - Write or error: go to DONE.
  - In-range read: go to WAIT with the latency counter loaded to RF_LAT.
- **WAIT:** the counter decrements each cycle. On the cycle it reads 1, rf_rdata is captured into the owner's rdata; then go to DONE.
- **DONE:** the owner's gnt and done are high. err is high if addr >= RF_DEPTH, in which case no rf_exec was issued and rdata is unchanged. Return to IDLE.

Output and arbitration rules:
- rf_addr, rf_wdata and rf_write are driven from the latched registers in every non-IDLE state; they are 0 in IDLE.
- rf_exec is high only in ISSUE.
- Only one gnt is ever high.
- A requester keeping req high after done is re-arbitrated in the following IDLE cycle. It is never served twice without returning to IDLE.
- Requests seen outside IDLE are ignored until IDLE.
- Address check is an unsigned compare of the full ADDR_W address.

Reset:
- Reset values: all outputs 0; m_rdata/s_rdata 0; FSM IDLE; last-owner register = S, so M wins the first tie.
- rst_n low in any state aborts the transaction: IDLE at the next edge, no done pulse, rdata not updated.

## Timing

Edge 0 samples req in IDLE.
- Write: rf_exec in cycle 1, done in cycle 2, IDLE in cycle 3. Back-to-back write throughput is 1 per 3 cycles.
- Read: rf_exec in cycle 1, WAIT in cycles 2..1+RF_LAT, rdata valid together with done in cycle 2+RF_LAT. For RF_LAT=1 that is done in cycle 3.
- Error: done+err in cycle 2, no rf_exec.
- Simultaneous m_req and s_req in IDLE: resolved per Configuration. The loser waits without any gnt.

## Configuration

Macro: REGFILE_ARB_ROUND_ROBIN_EN.
- **Defined:** round-robin. On a tie the port that was not the last owner wins; last owner updates on entry to ISSUE.
- **Undefined:** fixed priority, M always wins ties. S can starve under continuous M traffic; this is accepted for initialisation-phase use.
- Single-requester behaviour is identical in both modes.

## Test plan

- M write addr 5, data 0xDEADBEEF, S idle
  - rf_exec=1, rf_write=1, rf_addr=5, rf_wdata=0xDEADBEEF in cycle 1.
  - m_done in cycle 2; s_gnt never high.
- S read addr 5 after the above, RF model with RF_LAT=1
  - s_rdata=0xDEADBEEF and s_done in cycle 3; m_rdata stays 0.
- M and S both request continuously, 6 transactions
  - With REGFILE_ARB_ROUND_ROBIN_EN: owners alternate M,S,M,S,M,S.
  - Without it: all 6 grants go to M.
- M read addr 40 (RF_DEPTH=32)
  - No rf_exec.
  - m_done=1 and m_err=1 in cycle 2; m_rdata unchanged.
- rst_n low during WAIT of an S read
  - Next edge: busy=0, all outputs 0, no s_done, s_rdata=0.
  - New M request afterwards is granted normally.

Source files
------------

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: shares one register-file port between master (M) and slave (S) requesters
//
// One transaction at a time through IDLE -> ISSUE -> (WAIT) -> DONE.
// All outputs are registered.
//
// Parameters: ADDR_W address width, DATA_W data width,
//             RF_DEPTH valid entries (addr >= RF_DEPTH is an error),
//             RF_LAT register-file read latency after the exec cycle (>= 1).
//
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   m_req/m_write/m_addr/m_wdata  master request and its fields
//   s_req/s_write/s_addr/s_wdata  slave request and its fields
//   m_gnt/s_gnt                  port owns the register file
//   m_done/s_done                one-cycle completion pulse
//   m_err/s_err                  out-of-range address, valid with done
//   m_rdata/s_rdata              last successful read result per port
//   rf_exec/rf_write/rf_addr/rf_wdata  register-file access
//   rf_rdata                     register-file read data
//   busy                         FSM not in IDLE
//
// Macro REGFILE_ARB_ROUND_ROBIN_EN: round-robin tie-break when defined,
// fixed M-first priority otherwise.
module regfile_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int RF_DEPTH = 32,
    parameter int RF_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m_req,
    input  logic              m_write,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [DATA_W-1:0] m_wdata,
    input  logic              s_req,
    input  logic              s_write,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [DATA_W-1:0] s_wdata,
    output logic              m_gnt,
    output logic              m_done,
    output logic              m_err,
    output logic [DATA_W-1:0] m_rdata,
    output logic              s_gnt,
    output logic              s_done,
    output logic              s_err,
    output logic [DATA_W-1:0] s_rdata,
    output logic              rf_exec,
    output logic              rf_write,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    localparam int CW = $clog2(RF_LAT + 1);
    // one extra bit so the compare is a full unsigned compare of the address
    localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(RF_DEPTH);
    state_t          state;
    logic            owner_s;
    logic [CW-1:0]   cnt;
    logic            pick_s;
    logic            sel_in;
    logic            lat_in;
    logic [ADDR_W-1:0] sel_addr;
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
    logic last_s;
    assign pick_s = s_req && (!m_req || !last_s);
`else
    assign pick_s = s_req && !m_req;
`endif
    assign sel_addr = pick_s ? s_addr : m_addr;
    assign sel_in   = {1'b0, sel_addr} < DEPTH;
    // rf_write/rf_addr double as the latched transaction fields
    assign lat_in   = {1'b0, rf_addr} < DEPTH;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner_s  <= 1'b0;
            cnt      <= '0;
            m_gnt    <= 1'b0;
            s_gnt    <= 1'b0;
            m_done   <= 1'b0;
            s_done   <= 1'b0;
            m_err    <= 1'b0;
            s_err    <= 1'b0;
            m_rdata  <= '0;
            s_rdata  <= '0;
            rf_exec  <= 1'b0;
            rf_write <= 1'b0;
            rf_addr  <= '0;
            rf_wdata <= '0;
            busy     <= 1'b0;
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
            last_s   <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: if (m_req || s_req) begin
                    state    <= ISSUE;
                    owner_s  <= pick_s;
                    m_gnt    <= !pick_s;
                    s_gnt    <= pick_s;
                    rf_exec  <= sel_in;
                    rf_write <= pick_s ? s_write : m_write;
                    rf_addr  <= sel_addr;
                    rf_wdata <= pick_s ? s_wdata : m_wdata;
                    busy     <= 1'b1;
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
                    last_s   <= pick_s;
`endif
                end
                ISSUE: begin
                    rf_exec <= 1'b0;
                    if (rf_write || !lat_in) begin
                        state  <= DONE;
                        m_done <= !owner_s;
                        s_done <= owner_s;
                        m_err  <= !owner_s && !lat_in;
                        s_err  <= owner_s && !lat_in;
                    end else begin
                        state <= WAIT;
                        cnt   <= CW'(RF_LAT);
                    end
                end
                WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state  <= DONE;
                        m_done <= !owner_s;
                        s_done <= owner_s;
                        if (owner_s) s_rdata <= rf_rdata;
                        else m_rdata <= rf_rdata;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    m_gnt    <= 1'b0;
                    s_gnt    <= 1'b0;
                    m_done   <= 1'b0;
                    s_done   <= 1'b0;
                    m_err    <= 1'b0;
                    s_err    <= 1'b0;
                    rf_write <= 1'b0;
                    rf_addr  <= '0;
                    rf_wdata <= '0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: directed self-checking bench for regfile_arbiter
module tb_regfile_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        m_req, m_write, s_req, s_write;
    logic [31:0] m_addr, m_wdata, s_addr, s_wdata;
    logic        m_gnt, m_done, m_err, s_gnt, s_done, s_err;
    logic [31:0] m_rdata, s_rdata;
    logic        rf_exec, rf_write, busy;
    logic [31:0] rf_addr, rf_wdata, rf_rdata;
    logic [31:0] mem [0:63];
    int          vec = 0;
    int          miss = 0;

    regfile_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .m_req(m_req), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
        .s_req(s_req), .s_write(s_write), .s_addr(s_addr), .s_wdata(s_wdata),
        .m_gnt(m_gnt), .m_done(m_done), .m_err(m_err), .m_rdata(m_rdata),
        .s_gnt(s_gnt), .s_done(s_done), .s_err(s_err), .s_rdata(s_rdata),
        .rf_exec(rf_exec), .rf_write(rf_write), .rf_addr(rf_addr),
        .rf_wdata(rf_wdata), .rf_rdata(rf_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // register file with one cycle of read latency
    always @(posedge clk)
        if (rf_exec) begin
            if (rf_write) mem[rf_addr[5:0]] <= rf_wdata;
            rf_rdata <= mem[rf_addr[5:0]];
        end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        m_req = 0; m_write = 0; m_addr = 0; m_wdata = 0;
        s_req = 0; s_write = 0; s_addr = 0; s_wdata = 0;
        tick; tick;
        chk("rst busy", busy, 0);
        chk("rst m_gnt", m_gnt, 0);
        chk("rst s_gnt", s_gnt, 0);
        chk("rst rf_exec", rf_exec, 0);
        chk("rst m_rdata", m_rdata, 0);
        chk("rst s_rdata", s_rdata, 0);
        rst_n = 1'b1;
        tick;
        // M write addr 5
        m_req = 1; m_write = 1; m_addr = 5; m_wdata = 32'hDEADBEEF;
        tick;
        chk("w1 rf_exec", rf_exec, 1);
        chk("w1 rf_write", rf_write, 1);
        chk("w1 rf_addr", rf_addr, 5);
        chk("w1 rf_wdata", rf_wdata, 32'hDEADBEEF);
        chk("w1 m_gnt", m_gnt, 1);
        chk("w1 s_gnt", s_gnt, 0);
        tick;
        chk("w2 m_done", m_done, 1);
        chk("w2 m_err", m_err, 0);
        chk("w2 rf_exec", rf_exec, 0);
        chk("w2 s_gnt", s_gnt, 0);
        m_req = 0;
        tick;
        chk("w3 busy", busy, 0);
        chk("w3 m_done", m_done, 0);
        chk("w3 rf_addr", rf_addr, 0);
        // S read addr 5
        s_req = 1; s_write = 0; s_addr = 5;
        tick;
        chk("r1 s_gnt", s_gnt, 1);
        chk("r1 rf_exec", rf_exec, 1);
        chk("r1 rf_write", rf_write, 0);
        chk("r1 rf_addr", rf_addr, 5);
        tick;
        chk("r2 busy", busy, 1);
        chk("r2 s_done", s_done, 0);
        chk("r2 rf_exec", rf_exec, 0);
        tick;
        chk("r3 s_done", s_done, 1);
        chk("r3 s_rdata", s_rdata, 32'hDEADBEEF);
        chk("r3 m_rdata", m_rdata, 0);
        s_req = 0;
        tick;
        chk("r4 busy", busy, 0);
        chk("r4 s_rdata held", s_rdata, 32'hDEADBEEF);
        // both request continuously
        m_req = 1; m_write = 1; m_addr = 1; m_wdata = 32'h11;
        s_req = 1; s_write = 1; s_addr = 2; s_wdata = 32'h22;
        for (int i = 0; i < 6; i++) begin
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
            logic exp_s = (i % 2) == 1;
`else
            logic exp_s = 1'b0;
`endif
            tick;
            chk("tie m_gnt", m_gnt, !exp_s);
            chk("tie s_gnt", s_gnt, exp_s);
            tick;
            chk("tie done", exp_s ? s_done : m_done, 1);
            chk("tie other done", exp_s ? m_done : s_done, 0);
            tick;
            chk("tie idle", busy, 0);
        end
        m_req = 0; s_req = 0;
        tick;
        // M read out of range
        m_req = 1; m_write = 0; m_addr = 40;
        tick;
        chk("e1 m_gnt", m_gnt, 1);
        chk("e1 rf_exec", rf_exec, 0);
        tick;
        chk("e2 m_done", m_done, 1);
        chk("e2 m_err", m_err, 1);
        chk("e2 m_rdata", m_rdata, 0);
        m_req = 0;
        tick;
        chk("e3 m_err", m_err, 0);
        chk("e3 busy", busy, 0);
        // reset during WAIT of an S read
        s_req = 1; s_write = 0; s_addr = 5;
        tick;
        chk("a1 s_gnt", s_gnt, 1);
        tick;
        chk("a2 busy", busy, 1);
        rst_n = 0;
        s_req = 0;
        tick;
        chk("a3 busy", busy, 0);
        chk("a3 s_done", s_done, 0);
        chk("a3 s_gnt", s_gnt, 0);
        chk("a3 rf_addr", rf_addr, 0);
        chk("a3 s_rdata", s_rdata, 0);
        rst_n = 1;
        tick;
        // normal M traffic after abort
        m_req = 1; m_write = 1; m_addr = 7; m_wdata = 32'h1234;
        tick;
        chk("p1 m_gnt", m_gnt, 1);
        chk("p1 rf_exec", rf_exec, 1);
        chk("p1 rf_addr", rf_addr, 7);
        tick;
        chk("p2 m_done", m_done, 1);
        m_req = 0;
        tick;
        m_req = 1; m_write = 0; m_addr = 7;
        tick; tick; tick;
        chk("p3 m_done", m_done, 1);
        chk("p3 m_rdata", m_rdata, 32'h1234);
        m_req = 0;
        tick;
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
